game_input: RTL and testbench

- Input-conditioning stage directly upstream of game_state.
- Takes the five raw board pushbuttons (up, down, left, right, centre) and debounces each one.
- Produces the three control streams game_state consumes:
  - rotate_out: held 2-bit shield direction, to player/enemy.
  - key_input_out: one-cycle menu cursor pulses with auto-repeat, to menu.
  - decide_out: one-cycle confirm pulse, to menu.

---
 rtl/game_input_pkg.sv | 31 +++
 rtl/game_input_if.sv | 38 +++
 rtl/game_input_button_debounce.sv | 48 ++++
 rtl/game_input.sv | 145 ++++++++++++++
 tb/tb_game_input.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/game_input_pkg.sv
// rtl/game_input_pkg.sv - shared constants, repeat FSM states and helpers for game_input
package game_input_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Bit positions within held_out: {centre,right,down,left,up}
  localparam int BTN_UP     = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTRE = 4;
  localparam int NUM_BTN    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [1:0] key_pulse(input logic is_right);
    return is_right ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/game_input_if.sv
// rtl/game_input_if.sv - raw buttons in, conditioned control streams out
interface game_input_if;

  logic       btn_up_in;
  logic       btn_down_in;
  logic       btn_left_in;
  logic       btn_right_in;
  logic       btn_centre_in;
  logic [1:0] rotate_out;
  logic [1:0] key_input_out;
  logic       decide_out;
  logic [4:0] held_out;

  modport master (
    input  btn_up_in,
    input  btn_down_in,
    input  btn_left_in,
    input  btn_right_in,
    input  btn_centre_in,
    output rotate_out,
    output key_input_out,
    output decide_out,
    output held_out
  );

  modport slave (
    output btn_up_in,
    output btn_down_in,
    output btn_left_in,
    output btn_right_in,
    output btn_centre_in,
    input  rotate_out,
    input  key_input_out,
    input  decide_out,
    input  held_out
  );

endinterface

// File: rtl/game_input_button_debounce.sv
// rtl/game_input_button_debounce.sv - 2-flop synchronizer, debounce counter and rise detect
module button_debounce
  import game_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 371250
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_prev;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_level      <= 1'b0;
      r_level_prev <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1      <= raw_in;
      r_sync2      <= r_sync1;
      r_level_prev <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level_out = r_level;
  assign rise_out  = r_level & ~r_level_prev;

endmodule

// File: rtl/game_input.sv
// rtl/game_input.sv - debounced pushbuttons to shield direction, cursor auto-repeat and confirm pulse
module game_input
  import game_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 371250,
  parameter int REPEAT_DELAY    = 29700000,
  parameter int REPEAT_PERIOD   = 7425000
) (
  input logic          clk,
  input logic          rst,
  game_input_if.master bus
);

  localparam int RCW = (cnt_width(REPEAT_DELAY) > cnt_width(REPEAT_PERIOD)) ?
                       cnt_width(REPEAT_DELAY) : cnt_width(REPEAT_PERIOD);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_rise;

  assign w_raw[BTN_UP]     = bus.btn_up_in;
  assign w_raw[BTN_LEFT]   = bus.btn_left_in;
  assign w_raw[BTN_DOWN]   = bus.btn_down_in;
  assign w_raw[BTN_RIGHT]  = bus.btn_right_in;
  assign w_raw[BTN_CENTRE] = bus.btn_centre_in;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .raw_in   (w_raw[gi]),
      .level_out(w_level[gi]),
      .rise_out (w_rise[gi])
    );
  end

  logic [1:0] r_rotate;
  logic [1:0] w_rotate_next;
  logic       r_decide;

  always_comb begin
    w_rotate_next = r_rotate;
    if (w_rise[BTN_UP]) begin
      w_rotate_next = DIR_UP;
    end else if (w_rise[BTN_RIGHT]) begin
      w_rotate_next = DIR_RIGHT;
    end else if (w_rise[BTN_DOWN]) begin
      w_rotate_next = DIR_DOWN;
    end else if (w_rise[BTN_LEFT]) begin
      w_rotate_next = DIR_LEFT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rotate <= DIR_UP;
      r_decide <= 1'b0;
    end else begin
      r_rotate <= w_rotate_next;
      r_decide <= w_rise[BTN_CENTRE];
    end
  end

  // Cursor repeat: r_active selects the latched key (0 = left, 1 = right)
  rep_state_t     r_state;
  rep_state_t     w_state_next;
  logic [RCW-1:0] r_cnt;
  logic [RCW-1:0] w_cnt_next;
  logic           r_active;
  logic           w_active_next;
  logic [1:0]     r_key;
  logic [1:0]     w_key_next;
  logic           w_act_level;
  logic           w_other_rise;
  logic           w_both_held;

  assign w_act_level  = r_active ? w_level[BTN_RIGHT] : w_level[BTN_LEFT];
  assign w_other_rise = r_active ? w_rise[BTN_LEFT] : w_rise[BTN_RIGHT];
  assign w_both_held  = w_level[BTN_LEFT] & w_level[BTN_RIGHT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_key    <= 2'b00;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_active <= w_active_next;
      r_key    <= w_key_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_active_next = r_active;
    w_key_next    = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_rise[BTN_LEFT] ^ w_rise[BTN_RIGHT]) begin
          w_active_next = w_rise[BTN_RIGHT];
          w_key_next    = key_pulse(w_rise[BTN_RIGHT]);
          w_state_next  = DELAY;
          w_cnt_next    = '0;
        end
      end
      DELAY, REPEAT: begin
        if (!w_act_level) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (w_other_rise) begin
          // A fresh press of the other key wins over the both-held freeze
          w_active_next = ~r_active;
          w_key_next    = key_pulse(~r_active);
          w_state_next  = DELAY;
          w_cnt_next    = '0;
        end else if (w_both_held) begin
          w_cnt_next = r_cnt;
        end else if (r_cnt == ((r_state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
          w_key_next   = key_pulse(r_active);
          w_state_next = REPEAT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + RCW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign bus.rotate_out    = r_rotate;
  assign bus.key_input_out = r_key;
  assign bus.decide_out    = r_decide;
  assign bus.held_out      = w_level;

endmodule

// File: tb/tb_game_input.sv
// tb/tb_game_input.sv - directed self-checking bench for game_input
module tb_game_input;
  import game_input_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  game_input_if bus ();

  game_input #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic all_low();
    bus.btn_up_in     = 1'b0;
    bus.btn_down_in   = 1'b0;
    bus.btn_left_in   = 1'b0;
    bus.btn_right_in  = 1'b0;
    bus.btn_centre_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    all_low();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    all_low();
    @(negedge clk);
    step();
    chk("rst_rotate", bus.rotate_out, 0);
    chk("rst_key", bus.key_input_out, 0);
    chk("rst_decide", bus.decide_out, 0);
    chk("rst_held", bus.held_out, 0);
    chk("rst_state", dut.r_state, IDLE);
    rst = 1'b1;

    // Clean centre press: held_out from edge 6, single decide pulse at edge 7
    do_reset();
    bus.btn_centre_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      chk("decide_pulse", bus.decide_out, (e == 7));
      chk("held_centre", bus.held_out[BTN_CENTRE], (e >= 6));
    end
    all_low();
    for (int e = 1; e <= 10; e++) step();

    // Bounce rejection: 3 high / 1 low never reaches the debounce threshold
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.btn_up_in = ((i % 4) != 3);
      step();
      chk("bounce_held", bus.held_out[BTN_UP], 0);
    end
    bus.btn_up_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("bounce_held_low", bus.held_out[BTN_UP], 0);
    end
    chk("bounce_rotate", bus.rotate_out, 0);

    // Direction priority and hold after release
    do_reset();
    bus.btn_right_in = 1'b1;
    bus.btn_left_in  = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk("prio_rotate", bus.rotate_out, (e >= 7) ? 8'd1 : 8'd0);
      chk("prio_no_cursor", bus.key_input_out, 0);
    end
    chk("prio_state_idle", dut.r_state, IDLE);
    bus.btn_right_in = 1'b0;
    bus.btn_left_in  = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("prio_rel_no_cursor", bus.key_input_out, 0);
    end
    chk("prio_after_release", bus.rotate_out, 1);
    bus.btn_down_in = 1'b1;
    for (int e = 1; e <= 8; e++) step();
    chk("prio_down", bus.rotate_out, 2);
    bus.btn_down_in = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    chk("prio_down_release", bus.rotate_out, 2);

    // Auto-repeat on right: 7, 17, then every 3 until release takes effect at edge 46
    do_reset();
    bus.btn_right_in = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      step();
      chk("repeat_key", bus.key_input_out,
          ((e == 7) || (e >= 17 && e <= 44 && ((e - 17) % 3) == 0)) ? 8'd2 : 8'd0);
      if (e == 39) bus.btn_right_in = 1'b0;
    end
    chk("repeat_idle", dut.r_state, IDLE);

    // Conflict: left repeating, right pressed, then left released
    do_reset();
    bus.btn_left_in = 1'b1;
    for (int e = 1; e <= 62; e++) begin
      step();
      chk("conflict_key", bus.key_input_out,
          (e == 7 || e == 17 || e == 20 || e == 23 || e == 26) ? 8'd1 :
          (e == 27 || e == 51 || e == 54 || e == 57 || e == 60) ? 8'd2 : 8'd0);
      chk("conflict_rotate", bus.rotate_out, (e < 7) ? 8'd0 : (e < 27) ? 8'd3 : 8'd1);
      if (e == 30) chk("conflict_delay", dut.r_state, DELAY);
      if (e == 20) bus.btn_right_in = 1'b1;
      if (e == 35) bus.btn_left_in = 1'b0;
    end
    all_low();
    for (int e = 1; e <= 10; e++) step();

    // Asynchronous reset in REPEAT, then a fresh rise with the button still held
    do_reset();
    bus.btn_right_in = 1'b1;
    for (int e = 1; e <= 23; e++) begin
      step();
      chk("arst_pre_key", bus.key_input_out,
          (e == 7 || e == 17 || e == 20 || e == 23) ? 8'd2 : 8'd0);
    end
    chk("arst_pre_state", dut.r_state, REPEAT);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_rotate", bus.rotate_out, 0);
    chk("arst_key", bus.key_input_out, 0);
    chk("arst_decide", bus.decide_out, 0);
    chk("arst_held", bus.held_out, 0);
    step();
    step();
    rst = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("arst_post_key", bus.key_input_out, (e == 7) ? 8'd2 : 8'd0);
      chk("arst_post_rotate", bus.rotate_out, (e >= 7) ? 8'd1 : 8'd0);
    end
    all_low();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
